// File: rtl/riscv_core.sv
// riscv_core: 5-stage in-order RV32I-subset pipeline (IF/ID/EX/MEM/WB) with
// word-addressed instruction and data memories, forwarding and hazard control.

module riscv_insmem #(parameter int DEPTH = 32) (
    input  logic                     clk,
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [31:0]              load_data,
    input  logic [$clog2(DEPTH)-1:0] addr,
    output logic [31:0]              rdata
);
    logic [31:0] memfile [0:DEPTH-1];

    // Loading port only; contents are deliberately untouched by reset.
    always_ff @(posedge clk) begin
        if (load_en) memfile[load_addr] <= load_data;
    end

    assign rdata = memfile[addr];
endmodule

module riscv_datamem #(parameter int DEPTH = 32) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);
    logic [31:0] memfile [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) memfile[i] <= '0;
        end else if (we) begin
            memfile[addr] <= wdata;
        end
    end

    assign rdata = memfile[addr];
endmodule

module riscv_core #(parameter int MEMORY_DEPTH = 32) (
    input logic clk,
    input logic rst
);
    localparam int          AW      = $clog2(MEMORY_DEPTH);
    localparam logic [31:0] PC_MASK = 32'(MEMORY_DEPTH * 4 - 1);

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLL, ALU_SRL, ALU_PASSB
    } alu_op_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        alu_op_t     alu_op;
        logic        reg_we;
        logic        mem_rd;
        logic        mem_we;
        logic        branch;
        logic        bne;
        logic        jal;
        logic        alu_imm;
    } idex_t;

    typedef struct packed {
        logic        valid;
        logic        reg_we;
        logic        mem_rd;
        logic        mem_we;
        logic [4:0]  rd;
        logic [31:0] result;
        logic [31:0] store_data;
    } exmem_t;

    typedef struct packed {
        logic        valid;
        logic        reg_we;
        logic [4:0]  rd;
        logic [31:0] data;
    } memwb_t;

    logic [31:0] pc, instr_f, ifid_instr, ifid_pc;
    logic        ifid_valid;
    idex_t       idex, id_dec;
    exmem_t      exmem, ex_out;
    memwb_t      memwb, mem_out;
    logic [31:0] regs [0:31];

    riscv_insmem #(.DEPTH(MEMORY_DEPTH)) insmem (
        .clk(clk), .load_en(1'b0), .load_addr('0), .load_data('0),
        .addr(pc[AW+1:2]), .rdata(instr_f)
    );

    // ---------------- ID ----------------
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rs1_val, rs2_val, imm_i, imm_s, imm_b, imm_j, imm_u;
    logic        load_use;

    assign rs1   = ifid_instr[19:15];
    assign rs2   = ifid_instr[24:20];
    assign rd    = ifid_instr[11:7];
    assign imm_i = {{20{ifid_instr[31]}}, ifid_instr[31:20]};
    assign imm_s = {{20{ifid_instr[31]}}, ifid_instr[31:25], ifid_instr[11:7]};
    assign imm_b = {{19{ifid_instr[31]}}, ifid_instr[31], ifid_instr[7], ifid_instr[30:25], ifid_instr[11:8], 1'b0};
    assign imm_j = {{11{ifid_instr[31]}}, ifid_instr[31], ifid_instr[19:12], ifid_instr[20], ifid_instr[30:21], 1'b0};
    assign imm_u = {ifid_instr[31:12], 12'b0};

    // Write-before-read: WB result is visible to the ID read in the same cycle.
    assign rs1_val = (rs1 == 5'd0) ? '0 : (memwb.reg_we && memwb.rd == rs1) ? memwb.data : regs[rs1];
    assign rs2_val = (rs2 == 5'd0) ? '0 : (memwb.reg_we && memwb.rd == rs2) ? memwb.data : regs[rs2];

    assign load_use = ifid_valid && idex.mem_rd && idex.rd != 5'd0 && (idex.rd == rs1 || idex.rd == rs2);

    always_comb begin
        id_dec         = '0;
        id_dec.valid   = ifid_valid;
        id_dec.pc      = ifid_pc;
        id_dec.rs1     = rs1;
        id_dec.rs2     = rs2;
        id_dec.rd      = rd;
        id_dec.rs1_val = rs1_val;
        id_dec.rs2_val = rs2_val;
        id_dec.imm     = imm_i;
        id_dec.alu_op  = ALU_ADD;
        if (ifid_valid) begin
            case (ifid_instr[6:0])
                7'b0110011: begin
                    id_dec.reg_we = 1'b1;
                    case (ifid_instr[14:12])
                        3'b000:  id_dec.alu_op = ifid_instr[30] ? ALU_SUB : ALU_ADD;
                        3'b001:  id_dec.alu_op = ALU_SLL;
                        3'b010:  id_dec.alu_op = ALU_SLT;
                        3'b100:  id_dec.alu_op = ALU_XOR;
                        3'b101:  begin id_dec.alu_op = ALU_SRL; id_dec.reg_we = !ifid_instr[30]; end
                        3'b110:  id_dec.alu_op = ALU_OR;
                        3'b111:  id_dec.alu_op = ALU_AND;
                        default: id_dec.reg_we = 1'b0;
                    endcase
                end
                7'b0010011: begin
                    id_dec.reg_we  = 1'b1;
                    id_dec.alu_imm = 1'b1;
                    case (ifid_instr[14:12])
                        3'b000:  id_dec.alu_op = ALU_ADD;
                        3'b010:  id_dec.alu_op = ALU_SLT;
                        3'b110:  id_dec.alu_op = ALU_OR;
                        3'b111:  id_dec.alu_op = ALU_AND;
                        default: id_dec.reg_we = 1'b0;
                    endcase
                end
                7'b0000011: if (ifid_instr[14:12] == 3'b010) begin
                    id_dec.reg_we  = 1'b1;
                    id_dec.mem_rd  = 1'b1;
                    id_dec.alu_imm = 1'b1;
                end
                7'b0100011: if (ifid_instr[14:12] == 3'b010) begin
                    id_dec.mem_we  = 1'b1;
                    id_dec.alu_imm = 1'b1;
                    id_dec.imm     = imm_s;
                end
                7'b1100011: begin
                    id_dec.branch = (ifid_instr[14:13] == 2'b00);
                    id_dec.bne    = ifid_instr[12];
                    id_dec.imm    = imm_b;
                end
                7'b1101111: begin
                    id_dec.jal    = 1'b1;
                    id_dec.reg_we = 1'b1;
                    id_dec.imm    = imm_j;
                end
                7'b0110111: begin
                    id_dec.reg_we  = 1'b1;
                    id_dec.alu_imm = 1'b1;
                    id_dec.alu_op  = ALU_PASSB;
                    id_dec.imm     = imm_u;
                end
                default: ;
            endcase
        end
    end

    // ---------------- EX ----------------
    logic [31:0] fwd_a, fwd_b, op_b, alu_y, target;
    logic        taken;

    always_comb begin
        fwd_a = idex.rs1_val;
        if (exmem.reg_we && exmem.rd != 5'd0 && exmem.rd == idex.rs1)      fwd_a = exmem.result;
        else if (memwb.reg_we && memwb.rd != 5'd0 && memwb.rd == idex.rs1) fwd_a = memwb.data;
        fwd_b = idex.rs2_val;
        if (exmem.reg_we && exmem.rd != 5'd0 && exmem.rd == idex.rs2)      fwd_b = exmem.result;
        else if (memwb.reg_we && memwb.rd != 5'd0 && memwb.rd == idex.rs2) fwd_b = memwb.data;
    end

    assign op_b = idex.alu_imm ? idex.imm : fwd_b;

    always_comb begin
        alu_y = '0;
        case (idex.alu_op)
            ALU_ADD:   alu_y = fwd_a + op_b;
            ALU_SUB:   alu_y = fwd_a - op_b;
            ALU_AND:   alu_y = fwd_a & op_b;
            ALU_OR:    alu_y = fwd_a | op_b;
            ALU_XOR:   alu_y = fwd_a ^ op_b;
            ALU_SLT:   alu_y = {31'b0, $signed(fwd_a) < $signed(op_b)};
            ALU_SLL:   alu_y = fwd_a << op_b[4:0];
            ALU_SRL:   alu_y = fwd_a >> op_b[4:0];
            ALU_PASSB: alu_y = op_b;
            default:   alu_y = '0;
        endcase
    end

    assign taken  = idex.valid && (idex.jal || (idex.branch && ((fwd_a == fwd_b) != idex.bne)));
    assign target = (idex.pc + idex.imm) & PC_MASK;

    always_comb begin
        ex_out            = '0;
        ex_out.valid      = idex.valid;
        ex_out.reg_we     = idex.valid && idex.reg_we;
        ex_out.mem_rd     = idex.valid && idex.mem_rd;
        ex_out.mem_we     = idex.valid && idex.mem_we;
        ex_out.rd         = idex.rd;
        ex_out.result     = idex.jal ? ((idex.pc + 32'd4) & PC_MASK) : alu_y;
        ex_out.store_data = fwd_b;
    end

    // ---------------- MEM ----------------
    logic [31:0] dm_rdata;

    riscv_datamem #(.DEPTH(MEMORY_DEPTH)) datamem (
        .clk(clk), .rst(rst), .we(exmem.valid && exmem.mem_we),
        .addr(exmem.result[AW+1:2]), .wdata(exmem.store_data), .rdata(dm_rdata)
    );

    always_comb begin
        mem_out        = '0;
        mem_out.valid  = exmem.valid;
        mem_out.reg_we = exmem.valid && exmem.reg_we;
        mem_out.rd     = exmem.rd;
        mem_out.data   = exmem.mem_rd ? dm_rdata : exmem.result;
    end

    // ---------------- pipeline registers / WB ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= '0;
            ifid_valid <= 1'b0;
            ifid_instr <= '0;
            ifid_pc    <= '0;
            idex       <= '0;
            exmem      <= '0;
            memwb      <= '0;
        end else begin
            // A redirect overrides a simultaneous load-use stall.
            if (taken) begin
                pc         <= target;
                ifid_valid <= 1'b0;
                ifid_instr <= '0;
            end else if (!load_use) begin
                pc         <= (pc + 32'd4) & PC_MASK;
                ifid_valid <= 1'b1;
                ifid_instr <= instr_f;
                ifid_pc    <= pc;
            end
            if (taken || load_use) idex <= '0;
            else                   idex <= id_dec;
            exmem <= ex_out;
            memwb <= mem_out;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (memwb.valid && memwb.reg_we && memwb.rd != 5'd0) begin
            regs[memwb.rd] <= memwb.data;
        end
    end
endmodule

// File: tb/tb_riscv_core.sv
// Directed bench for riscv_core: hand-assembled programs, expected memory and
// register contents and store timing computed by hand.

module tb_riscv_core;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    localparam logic [6:0] OPI = 7'b0010011;
    localparam logic [6:0] OPL = 7'b0000011;

    logic [31:0] prog [0:31];
    logic [31:0] exp1 [0:13];

    always #5 clk = ~clk;

    riscv_core #(.MEMORY_DEPTH(32)) dut (.clk(clk), .rst(rst));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, want);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load_prog();
        for (int i = 0; i < 32; i++) dut.insmem.memfile[i] = prog[i];
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd);
        return {imm, rd, 7'b0110111};
    endfunction

    task automatic check_p1(input string pfx);
        for (int i = 0; i < 14; i++)
            chk($sformatf("%s_dm%0d", pfx, i), dut.datamem.memfile[i], exp1[i]);
        chk({pfx, "_x1"}, dut.regs[1], 32'd5);
        chk({pfx, "_x5"}, dut.regs[5], 32'd24);
    endtask

    initial begin
        // Program 1: forwarding, load-use stall, ALU ops, immediates, lui
        for (int i = 0; i < 32; i++) prog[i] = '0;
        prog[0]  = enc_i(12'd5, 5'd0, 3'b000, 5'd1, OPI);
        prog[1]  = enc_i(12'd7, 5'd0, 3'b000, 5'd2, OPI);
        prog[2]  = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);
        prog[3]  = enc_s(12'd0, 5'd3, 5'd0);
        prog[4]  = enc_i(12'd0, 5'd0, 3'b010, 5'd4, OPL);
        prog[5]  = enc_r(7'h00, 5'd4, 5'd4, 3'b000, 5'd5);
        prog[6]  = enc_s(12'd4, 5'd5, 5'd0);
        prog[7]  = enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd8);
        prog[8]  = enc_s(12'd20, 5'd8, 5'd0);
        prog[9]  = enc_r(7'h00, 5'd1, 5'd8, 3'b010, 5'd9);
        prog[10] = enc_s(12'd24, 5'd9, 5'd0);
        prog[11] = enc_r(7'h00, 5'd2, 5'd1, 3'b100, 5'd10);
        prog[12] = enc_s(12'd28, 5'd10, 5'd0);
        prog[13] = enc_r(7'h00, 5'd2, 5'd1, 3'b001, 5'd11);
        prog[14] = enc_s(12'd32, 5'd11, 5'd0);
        prog[15] = enc_r(7'h00, 5'd1, 5'd8, 3'b101, 5'd12);
        prog[16] = enc_s(12'd36, 5'd12, 5'd0);
        prog[17] = enc_i(12'h0F0, 5'd8, 3'b111, 5'd13, OPI);
        prog[18] = enc_s(12'd40, 5'd13, 5'd0);
        prog[19] = enc_i(12'hFF0, 5'd1, 3'b110, 5'd14, OPI);
        prog[20] = enc_s(12'd44, 5'd14, 5'd0);
        prog[21] = enc_i(12'hFFF, 5'd8, 3'b010, 5'd15, OPI);
        prog[22] = enc_s(12'd48, 5'd15, 5'd0);
        prog[23] = enc_u(20'hABCDE, 5'd16);
        prog[24] = enc_s(12'd52, 5'd16, 5'd0);

        exp1[0]  = 32'd12;        exp1[1]  = 32'd24;        exp1[2]  = 32'd0;
        exp1[3]  = 32'd0;         exp1[4]  = 32'd0;         exp1[5]  = 32'hFFFF_FFFE;
        exp1[6]  = 32'd1;         exp1[7]  = 32'd2;         exp1[8]  = 32'd640;
        exp1[9]  = 32'h07FF_FFFF; exp1[10] = 32'h0000_00F0; exp1[11] = 32'hFFFF_FFF5;
        exp1[12] = 32'd1;         exp1[13] = 32'hABCD_E000;

        load_prog();
        rst = 1'b1;
        tick(2);
        chk("rst_dm0", dut.datamem.memfile[0], 32'd0);
        chk("rst_dm31", dut.datamem.memfile[31], 32'd0);
        chk("rst_x5", dut.regs[5], 32'd0);

        rst = 1'b0;
        tick(6);
        chk("p1_sw0_before", dut.datamem.memfile[0], 32'd0);
        tick(1);
        chk("p1_sw0_at7", dut.datamem.memfile[0], 32'd12);
        tick(3);
        chk("p1_sw1_before", dut.datamem.memfile[1], 32'd0);
        tick(1);
        chk("p1_sw1_at11", dut.datamem.memfile[1], 32'd24);
        tick(21);
        check_p1("p1");

        // Restart, then reset mid-program while a store is in MEM
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(10);
        rst = 1'b1;
        tick(1);
        chk("midrst_dm0", dut.datamem.memfile[0], 32'd0);
        chk("midrst_dm1", dut.datamem.memfile[1], 32'd0);
        chk("midrst_x1", dut.regs[1], 32'd0);
        rst = 1'b0;
        tick(32);
        check_p1("rerun");

        // Program 2: jal, beq/bne taken and not taken, x0 writes, unknown opcode
        for (int i = 0; i < 32; i++) prog[i] = '0;
        prog[0]  = enc_j(21'd8, 5'd7);
        prog[1]  = enc_i(12'd99, 5'd0, 3'b000, 5'd20, OPI);
        prog[2]  = enc_s(12'd12, 5'd7, 5'd0);
        prog[3]  = enc_b(13'd8, 5'd0, 5'd0, 3'b000);
        prog[4]  = enc_i(12'd1, 5'd0, 3'b000, 5'd6, OPI);
        prog[5]  = enc_s(12'd8, 5'd6, 5'd0);
        prog[6]  = enc_s(12'd60, 5'd20, 5'd0);
        prog[7]  = enc_i(12'd33, 5'd0, 3'b000, 5'd21, OPI);
        prog[8]  = enc_s(12'd16, 5'd21, 5'd0);
        prog[9]  = enc_i(12'd9, 5'd0, 3'b000, 5'd0, OPI);
        prog[10] = enc_s(12'd16, 5'd0, 5'd0);
        prog[11] = enc_i(12'd1, 5'd0, 3'b000, 5'd22, OPI);
        prog[12] = enc_b(13'd8, 5'd0, 5'd22, 3'b001);
        prog[13] = enc_i(12'd5, 5'd0, 3'b000, 5'd23, OPI);
        prog[14] = enc_b(13'd8, 5'd0, 5'd0, 3'b001);
        prog[15] = enc_i(12'd3, 5'd0, 3'b000, 5'd24, OPI);
        prog[16] = 32'hFFFF_FFFF;
        prog[17] = enc_s(12'd20, 5'd23, 5'd0);
        prog[18] = enc_s(12'd24, 5'd24, 5'd0);
        prog[19] = enc_s(12'd28, 5'd31, 5'd0);

        rst = 1'b1;
        load_prog();
        tick(2);
        rst = 1'b0;
        tick(6);
        chk("p2_jal_sw_before", dut.datamem.memfile[3], 32'd0);
        tick(1);
        chk("p2_jal_sw_at7", dut.datamem.memfile[3], 32'd4);
        tick(25);
        chk("p2_beq_flush_dm2", dut.datamem.memfile[2], 32'd0);
        chk("p2_jal_link_dm3", dut.datamem.memfile[3], 32'd4);
        chk("p2_x0_store_dm4", dut.datamem.memfile[4], 32'd0);
        chk("p2_bne_flush_dm5", dut.datamem.memfile[5], 32'd0);
        chk("p2_bne_fall_dm6", dut.datamem.memfile[6], 32'd3);
        chk("p2_nop_op_dm7", dut.datamem.memfile[7], 32'd0);
        chk("p2_jal_flush_dm15", dut.datamem.memfile[15], 32'd0);
        chk("p2_x0", dut.regs[0], 32'd0);
        chk("p2_x7", dut.regs[7], 32'd4);
        chk("p2_x21", dut.regs[21], 32'd33);
        chk("p2_x20", dut.regs[20], 32'd0);
        chk("p2_x31", dut.regs[31], 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
